// File: rtl/super_pkg.sv
// ----------------------------------------------------------------------------
// super_pkg
// Shared types and constants for the 64-to-32-bit instruction fetch adapter
// (ifetch_bus_narrow64 and its response merger ifetch_narrow_resp).
//   ifn_state_e    : issue FSM state (IDLE = waiting for a fetch / low beat,
//                    HI = low beat granted, high beat being requested)
//   IFN_WORD_BYTES : byte stride between the two 32-bit beats of one fetch
// ----------------------------------------------------------------------------
package super_pkg;

  typedef enum logic {
    IFN_IDLE = 1'b0,
    IFN_HI   = 1'b1
  } ifn_state_e;

  localparam int unsigned IFN_WORD_BYTES = 4;

endpackage

// File: rtl/ifetch_narrow_resp.sv
// ----------------------------------------------------------------------------
// ifetch_narrow_resp
// Merges two in-order 32-bit memory responses into one 64-bit fetch response.
// A phase bit tracks which beat of the current fetch arrives next; the low
// word and its error flag are parked until the high word shows up.
//
// Optional feature (macro IFETCH_NARROW_REG_RESP_EN):
//   defined   : merged response is registered, presented 1 cycle after the
//               high-word rvalid; o_done pulses with the registered response.
//   undefined : merged response is combinational, same cycle as the
//               high-word rvalid; o_done pulses with it.
//
// Ports
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   i_rvalid      : accepted 32-bit response beat (already qualified)
//   i_rdata/i_err : 32-bit response data / error
//   o_rvalid      : 64-bit response valid
//   o_rdata       : {hi_word, lo_word}, zero when o_rvalid is low
//   o_err         : error on either beat, zero when o_rvalid is low
//   o_done        : one fetch retired (drives the outstanding counter)
// ----------------------------------------------------------------------------
module ifetch_narrow_resp (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_rvalid,
  input  logic [31:0] i_rdata,
  input  logic        i_err,
  output logic        o_rvalid,
  output logic [63:0] o_rdata,
  output logic        o_err,
  output logic        o_done
);

  // r_phase: 0 = next beat is the low word, 1 = next beat is the high word
  logic        r_phase;
  logic [31:0] r_lo;
  logic        r_lo_err;

  logic        w_hi_fire;
  logic [63:0] w_merged_data;
  logic        w_merged_err;

  assign w_hi_fire     = i_rvalid & r_phase;
  assign w_merged_data = {i_rdata, r_lo};
  assign w_merged_err  = r_lo_err | i_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_phase  <= 1'b0;
      r_lo     <= '0;
      r_lo_err <= 1'b0;
    end else if (i_rvalid) begin
      r_phase <= ~r_phase;
      if (!r_phase) begin
        r_lo     <= i_rdata;
        r_lo_err <= i_err;
      end
    end
  end

`ifdef IFETCH_NARROW_REG_RESP_EN
  logic        r_rvalid;
  logic [63:0] r_rdata;
  logic        r_err;

  // Data/error registers are loaded with zero on non-response cycles so the
  // outputs are already clean whenever r_rvalid is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_hi_fire;
      r_rdata  <= w_hi_fire ? w_merged_data : 64'd0;
      r_err    <= w_hi_fire & w_merged_err;
    end
  end

  assign o_rvalid = r_rvalid;
  assign o_rdata  = r_rdata;
  assign o_err    = r_err;
  assign o_done   = r_rvalid;
`else
  assign o_rvalid = w_hi_fire;
  assign o_rdata  = w_hi_fire ? w_merged_data : 64'd0;
  assign o_err    = w_hi_fire & w_merged_err;
  assign o_done   = w_hi_fire;
`endif

endmodule

// File: rtl/ifetch_bus_narrow64.sv
// ----------------------------------------------------------------------------
// ifetch_bus_narrow64
// Width adapter between a 64-bit fetch port and a 32-bit instruction bus.
// Each fetch is issued as two in-order 32-bit beats (addr, addr+4); the two
// responses are merged into one 64-bit response by ifetch_narrow_resp.
// A counter bounds the number of fetches whose low beat has been granted but
// whose merged response has not yet been returned.
//
// Optional feature (macro IFETCH_NARROW_REG_RESP_EN): registered response
// path with one cycle of latency; see ifetch_narrow_resp.
//
// Handshakes: a request (f_req_i / mem_req_o) is held with its address stable
// until the matching grant; the transfer happens in the cycle where request
// and grant are both high. Responses (mem_rvalid_i / f_rvalid_o) are
// single-cycle pulses with no back-pressure, returned in issue order.
//
// Ports
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   f_req_i/f_addr_i/f_gnt_o : 64-bit fetch request side
//   f_rvalid_o/f_rdata_o/f_err_o : 64-bit fetch response side
//   mem_req_o/mem_gnt_i/mem_addr_o : 32-bit bus request side
//   mem_rvalid_i/mem_rdata_i/mem_err_i : 32-bit bus response side
//   busy_o                   : issue FSM not idle or any fetch outstanding
// ----------------------------------------------------------------------------
module ifetch_bus_narrow64
  import super_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        f_req_i,
  output logic        f_gnt_o,
  input  logic [31:0] f_addr_i,
  output logic        f_rvalid_o,
  output logic [63:0] f_rdata_o,
  output logic        f_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  input  logic        mem_rvalid_i,
  output logic        busy_o
);

  localparam int unsigned   CntW   = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxOutstanding);

  ifn_state_e      r_state;
  ifn_state_e      w_state_nxt;
  logic [31:0]     r_hi_addr;
  logic [CntW-1:0] r_cnt;

  logic            w_lo_fire;
  logic            w_rvalid_acc;
  logic            w_resp_done;
  logic [1:0]      w_unused_addr_bits;

  // Fetch addresses are word aligned; the low bits are dropped on purpose.
  assign w_unused_addr_bits = f_addr_i[1:0];

  // ---------------- issue FSM ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IFN_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_req_o   = 1'b0;
    mem_addr_o  = {f_addr_i[31:2], 2'b00};
    f_gnt_o     = 1'b0;
    w_lo_fire   = 1'b0;
    case (r_state)
      IFN_IDLE: begin
        // Only the low beat is throttled: a fetch in HI is already counted.
        mem_req_o = f_req_i & (r_cnt < CntMax);
        if (mem_req_o && mem_gnt_i) begin
          w_lo_fire   = 1'b1;
          w_state_nxt = IFN_HI;
        end
      end
      IFN_HI: begin
        mem_req_o  = 1'b1;
        mem_addr_o = r_hi_addr;
        if (mem_gnt_i) begin
          f_gnt_o     = 1'b1;
          w_state_nxt = IFN_IDLE;
        end
      end
      default: w_state_nxt = IFN_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hi_addr <= '0;
    end else if (w_lo_fire) begin
      r_hi_addr <= mem_addr_o + 32'(IFN_WORD_BYTES);  // wraps at 2^32
    end
  end

  // ---------------- outstanding-fetch counter ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else begin
      case ({w_lo_fire, w_resp_done})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;  // none, or issue and retire together
      endcase
    end
  end

  // A response with nothing outstanding is a bus protocol error; drop it.
  assign w_rvalid_acc = mem_rvalid_i & (r_cnt != '0);

  a_no_stray_rvalid: assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(mem_rvalid_i && (r_cnt == '0))
  );

  // ---------------- response merge ----------------
  ifetch_narrow_resp u_resp (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_rvalid (w_rvalid_acc),
    .i_rdata  (mem_rdata_i),
    .i_err    (mem_err_i),
    .o_rvalid (f_rvalid_o),
    .o_rdata  (f_rdata_o),
    .o_err    (f_err_o),
    .o_done   (w_resp_done)
  );

  assign busy_o = (r_state != IFN_IDLE) | (r_cnt != '0);

endmodule

// File: tb/tb_ifetch_bus_narrow64.sv
// ----------------------------------------------------------------------------
// tb_ifetch_bus_narrow64
// Self-checking bench for ifetch_bus_narrow64: a directed vector table,
// a hand-written same-cycle issue/retire sequence, and a randomized run
// against a transaction-level memory/fetch model.
// Inputs are driven on the falling edge, outputs sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_ifetch_bus_narrow64;

  localparam int MAX_OUT = 3;
`ifdef IFETCH_NARROW_REG_RESP_EN
  localparam int RESP_LAT = 1;
`else
  localparam int RESP_LAT = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        f_req_i, f_gnt_o, f_rvalid_o, f_err_o;
  logic [31:0] f_addr_i;
  logic [63:0] f_rdata_o;
  logic        mem_req_o, mem_gnt_i, mem_err_i, mem_rvalid_i, busy_o;
  logic [31:0] mem_addr_o, mem_rdata_i;

  ifetch_bus_narrow64 #(.MaxOutstanding(MAX_OUT)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .f_req_i      (f_req_i),
    .f_gnt_o      (f_gnt_o),
    .f_addr_i     (f_addr_i),
    .f_rvalid_o   (f_rvalid_o),
    .f_rdata_o    (f_rdata_o),
    .f_err_o      (f_err_o),
    .mem_req_o    (mem_req_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_addr_o   (mem_addr_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_err_i    (mem_err_i),
    .mem_rvalid_i (mem_rvalid_i),
    .busy_o       (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic req, input logic [31:0] addr, input logic gnt,
                       input logic rv, input logic [31:0] rdata, input logic err);
    @(negedge clk);
    f_req_i      = req;
    f_addr_i     = addr;
    mem_gnt_i    = gnt;
    mem_rvalid_i = rv;
    mem_rdata_i  = rdata;
    mem_err_i    = err;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        f_req;
    logic [31:0] f_addr;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_gnt;
    logic        e_rv;
    logic [63:0] e_data;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic req, logic [31:0] addr, logic gnt,
                              logic rv, logic [31:0] rdata, logic err,
                              logic e_req, logic [31:0] e_addr, logic e_gnt,
                              logic e_rv, logic [63:0] e_data, logic e_err);
    vec_t v;
    v.f_req = req;  v.f_addr = addr;  v.gnt = gnt;
    v.rv = rv;      v.rdata = rdata;  v.err = err;
    v.e_req = e_req; v.e_addr = e_addr; v.e_gnt = e_gnt;
    v.e_rv = e_rv;  v.e_data = e_data; v.e_err = e_err;
    return v;
  endfunction

  // ---------------- random-run scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        hi;
  } beat_t;

  beat_t       pend_q[$];
  logic [31:0] exp_addr_q[$];
  logic [64:0] exp_q[$];

  initial begin
    vec_t        v, prev, r;
    beat_t       b;
    logic [31:0] lo_data, cur_addr, a;
    logic        lo_err, fetch_active, next_is_hi, hi_granted;
    logic [64:0] e;
    int          outstanding, max_out, n_rv, budget;

    f_req_i = 0; f_addr_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 0; mem_rdata_i = 0; mem_err_i = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset f_gnt_o", f_gnt_o, 0);
    check("reset f_rvalid_o", f_rvalid_o, 0);
    check("reset f_rdata_o", f_rdata_o, 0);
    check("reset f_err_o", f_err_o, 0);
    check("reset mem_req_o", mem_req_o, 0);
    check("reset busy_o", busy_o, 0);
    rst_n = 1'b1;

    // ----- directed table: basic fetch, HI stall, wrap, full, errors -----
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 1, 0, 0, 0,                1, 32'h1000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1000, 1, 0, 0, 0,                1, 32'h1004, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h11111111, 0,            0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h22222222, 0,            0, 0, 0, 1, 64'h22222222_11111111, 0));
    vecs.push_back(mk(1, 32'h2000, 1, 0, 0, 0,                1, 32'h2000, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 32'h2000, 0, 0, 0, 0,              1, 32'h2004, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h2000, 1, 0, 0, 0,                1, 32'h2004, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFFFFF8, 1, 0, 0, 0,            1, 32'hFFFFFFF8, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFFFFF8, 1, 0, 0, 0,            1, 32'hFFFFFFFC, 1, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFFFFFF, 1, 0, 0, 0,            1, 32'hFFFFFFFC, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hFFFFFFFF, 1, 0, 0, 0,            1, 32'h00000000, 1, 0, 0, 0));
    // three fetches outstanding: request blocked until one retires
    vecs.push_back(mk(1, 32'h3000, 1, 0, 0, 0,                0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h3000, 1, 1, 32'hAAAA0000, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h3000, 0, 1, 32'hBBBB0001, 0,     0, 0, 0, 1, 64'hBBBB0001_AAAA0000, 0));
    vecs.push_back(mk(1, 32'h3000, 0, 0, 0, 0,                (RESP_LAT == 0), 32'h3000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h3000, 1, 0, 0, 0,                1, 32'h3000, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'h3000, 1, 0, 0, 0,                1, 32'h3004, 1, 0, 0, 0));
    // low-beat error, then high-beat error, then clean
    vecs.push_back(mk(0, 0, 0, 1, 32'hCCCC0002, 1,            0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hDDDD0003, 0,            0, 0, 0, 1, 64'hDDDD0003_CCCC0002, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'hEEEE0004, 0,            0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'hFFFF0005, 1,            0, 0, 0, 1, 64'hFFFF0005_EEEE0004, 1));
    vecs.push_back(mk(0, 0, 0, 1, 32'h33330006, 0,            0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 32'h44440007, 0,            0, 0, 0, 1, 64'h44440007_33330006, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0,                       0, 0, 0, 0, 0, 0));

    prev = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.f_req, v.f_addr, v.gnt, v.rv, v.rdata, v.err);
      check($sformatf("vec%0d mem_req_o", i), mem_req_o, v.e_req);
      if (v.e_req) check($sformatf("vec%0d mem_addr_o", i), mem_addr_o, v.e_addr);
      check($sformatf("vec%0d f_gnt_o", i), f_gnt_o, v.e_gnt);
      // the response columns refer to the high-beat cycle; shift when registered
      r = (RESP_LAT != 0) ? prev : v;
      check($sformatf("vec%0d f_rvalid_o", i), f_rvalid_o, r.e_rv);
      check($sformatf("vec%0d f_rdata_o", i), f_rdata_o, r.e_data);
      check($sformatf("vec%0d f_err_o", i), f_err_o, r.e_err);
      prev = v;
    end
    check("table end busy_o", busy_o, 0);

    // ----- low-beat grant in the same cycle as a high-word rvalid -----
    drive(1, 32'h5000, 1, 0, 0, 0);
    drive(1, 32'h5000, 1, 0, 0, 0);
    check("seq 5000 f_gnt_o", f_gnt_o, 1);
    drive(0, 0, 0, 1, 32'h55550000, 0);
    drive(1, 32'h6000, 1, 1, 32'h55550001, 0);
    check("seq overlap mem_req_o", mem_req_o, 1);
    check("seq overlap mem_addr_o", mem_addr_o, 32'h6000);
    check("seq overlap f_rvalid_o", f_rvalid_o, (RESP_LAT == 0));
    drive(1, 32'h6000, 1, 0, 0, 0);
    check("seq 6000 f_gnt_o", f_gnt_o, 1);
    drive(1, 32'h7000, 1, 0, 0, 0);
    drive(1, 32'h7000, 1, 0, 0, 0);
    drive(1, 32'h8000, 1, 0, 0, 0);
    drive(1, 32'h8000, 1, 0, 0, 0);
    check("seq 8000 f_gnt_o", f_gnt_o, 1);
    drive(1, 32'h9000, 1, 0, 0, 0);
    check("seq full mem_req_o", mem_req_o, 0);
    check("seq full busy_o", busy_o, 1);
    n_rv = 0;
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, (i < 6), 32'h60000000 + i, 0);
      if (f_rvalid_o) n_rv++;
    end
    drive(0, 0, 0, 0, 0, 0);
    if (f_rvalid_o) n_rv++;
    check("seq drain rvalid count", n_rv, 3);
    check("seq drain busy_o", busy_o, 0);

    // ----- randomized run against the transaction model -----
    outstanding = 0; max_out = 0; fetch_active = 0; next_is_hi = 0;
    lo_data = 0; lo_err = 0; cur_addr = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (!fetch_active && cyc < 2500 && $urandom_range(0, 3) != 0) begin
        fetch_active = 1;
        if ($urandom_range(0, 7) == 0) cur_addr = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
        else                           cur_addr = $urandom;
        a = {cur_addr[31:2], 2'b00};
        exp_addr_q.push_back(a);
        exp_addr_q.push_back(a + 32'd4);
      end
      f_req_i   = fetch_active;
      f_addr_i  = cur_addr;
      mem_gnt_i = ($urandom_range(0, 1) == 1);
      if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        b = pend_q.pop_front();
        mem_rvalid_i = 1; mem_rdata_i = b.data; mem_err_i = b.err;
        if (!b.hi) begin
          lo_data = b.data; lo_err = b.err;
        end else begin
          exp_q.push_back({lo_err | b.err, b.data, lo_data});
          outstanding--;
        end
      end else begin
        mem_rvalid_i = 0; mem_rdata_i = $urandom; mem_err_i = 1'($urandom_range(0, 1));
      end
      #1;
      hi_granted = 0;
      if (mem_req_o && mem_gnt_i) begin
        if (exp_addr_q.size() == 0) begin
          check($sformatf("rnd%0d unexpected beat", cyc), mem_addr_o, 0);
        end else begin
          check($sformatf("rnd%0d mem_addr_o", cyc), mem_addr_o, exp_addr_q.pop_front());
          b.data = $urandom; b.err = ($urandom_range(0, 7) == 0); b.hi = next_is_hi;
          pend_q.push_back(b);
          if (next_is_hi) begin
            hi_granted = 1;
            fetch_active = 0;
          end else begin
            outstanding++;
            if (outstanding > max_out) max_out = outstanding;
          end
          next_is_hi = ~next_is_hi;
        end
      end
      check($sformatf("rnd%0d f_gnt_o", cyc), f_gnt_o, hi_granted);
      if (f_rvalid_o) begin
        if (exp_q.size() == 0) begin
          check($sformatf("rnd%0d unexpected rvalid", cyc), f_rvalid_o, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("rnd%0d f_rdata_o", cyc), f_rdata_o, e[63:0]);
          check($sformatf("rnd%0d f_err_o", cyc), f_err_o, e[64]);
        end
      end else begin
        check($sformatf("rnd%0d idle f_rdata_o/f_err_o", cyc), {f_err_o, f_rdata_o}, 0);
      end
    end
    check("rnd max outstanding within bound", (max_out <= MAX_OUT), 1);

    // drain: anything still pending must come back within a bounded time
    budget = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && budget < 200) begin
      @(negedge clk);
      f_req_i = 0; mem_gnt_i = 0;
      if (pend_q.size() > 0) begin
        b = pend_q.pop_front();
        mem_rvalid_i = 1; mem_rdata_i = b.data; mem_err_i = b.err;
        if (!b.hi) begin
          lo_data = b.data; lo_err = b.err;
        end else begin
          exp_q.push_back({lo_err | b.err, b.data, lo_data});
        end
      end else begin
        mem_rvalid_i = 0; mem_err_i = 0;
      end
      #1;
      if (f_rvalid_o && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("drain f_rdata_o", f_rdata_o, e[63:0]);
        check("drain f_err_o", f_err_o, e[64]);
      end
      budget++;
    end
    drive(0, 0, 0, 0, 0, 0);
    check("drain leftover responses", exp_q.size() + pend_q.size(), 0);
    check("drain leftover beat addresses", exp_addr_q.size(), 0);
    check("final busy_o", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
